alu_op_sequencer: RTL and testbench

- Upstream issue stage for the 4-bit ALU. Holds a 4-entry x 4-bit register file, accepts register-addressed instructions over a valid/ready handshake, and drives the ALU's A, B and 3-bit control inputs from registers.
- Captures the ALU result, writes it back to the register file, and reports completion with a zero flag.
- The ALU itself stays external and combinational. This block wraps the ALU into a sequential datapath.

---
 rtl/alu_op_sequencer.sv | 108 ++++++++++
 tb/tb_alu_op_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue stage for an external combinational 4-bit ALU.
// Holds a 4 x 4-bit register file and accepts register-addressed instructions
// over a valid/ready handshake. It presents registered operands and control to
// the ALU, then writes the ALU result back with a zero flag and a done pulse.
// Optional feature: define ALU_SEQ_PERF_EN to add a saturating op_count output.
module alu_op_sequencer #(
    parameter int NREG = 4,
    parameter int DW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [1:0]    instr_rd,
    input  logic [1:0]    instr_rs1,
    input  logic [1:0]    instr_rs2,
    input  logic          ld_en,
    input  logic [1:0]    ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_ctrl,
    input  logic [DW-1:0] alu_result,
    output logic          done,
    output logic [DW-1:0] res_q,
    output logic          zero_q,
    input  logic [1:0]    rd_addr,
`ifdef ALU_SEQ_PERF_EN
    output logic [DW-1:0] rd_data,
    output logic [7:0]    op_count
`else
    output logic [DW-1:0] rd_data
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] rf [NREG];
    logic [1:0]    rd_q;   // destination latched at accept, used at writeback

    // Ready is a pure decode of the registered state, no path from instr_valid.
    assign instr_ready = (state == IDLE);

    // Debug read port.
    assign rd_data = rf[rd_addr];

    // Issue FSM, register file, operand latches and writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rf       <= '{default: '0};
            rd_q     <= 2'd0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= 3'b000;
            done     <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b1;
`ifdef ALU_SEQ_PERF_EN
            op_count <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Loads are only honoured while idle.
                    if (ld_en) begin
                        rf[ld_addr] <= ld_data;
                    end
                    if (instr_valid) begin
                        // Operands bypass a load landing in the same cycle.
                        alu_a    <= (ld_en && (ld_addr == instr_rs1)) ? ld_data : rf[instr_rs1];
                        alu_b    <= (ld_en && (ld_addr == instr_rs2)) ? ld_data : rf[instr_rs2];
                        alu_ctrl <= instr_op;
                        rd_q     <= instr_rd;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Operands were latched at accept, so rd may alias rs1/rs2.
                    rf[rd_q] <= alu_result;
                    res_q    <= alu_result;
                    zero_q   <= (alu_result == '0);
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
`ifdef ALU_SEQ_PERF_EN
                    if (op_count != 8'hFF) begin
                        op_count <= op_count + 8'd1;
                    end
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench for alu_op_sequencer with a behavioural
// model of the external 4-bit ALU driving alu_result.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs1;
    logic [1:0] instr_rs2;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_ctrl;
    logic [3:0] alu_result;
    logic       done;
    logic [3:0] res_q;
    logic       zero_q;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
`ifdef ALU_SEQ_PERF_EN
    logic [7:0] op_count;
`endif

    int errors = 0;
    int checks = 0;

    alu_op_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .done        (done),
        .res_q       (res_q),
        .zero_q      (zero_q),
        .rd_addr     (rd_addr),
`ifdef ALU_SEQ_PERF_EN
        .rd_data     (rd_data),
        .op_count    (op_count)
`else
        .rd_data     (rd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU.
    always_comb begin
        alu_result = 4'h0;
        case (alu_ctrl)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: alu_result = alu_a + alu_b;
            3'b011: alu_result = alu_a - alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = ~(alu_a | alu_b);
            3'b110: alu_result = ~(alu_a & alu_b);
            default: alu_result = ~alu_a;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input logic [1:0] addr, input logic [3:0] exp);
        rd_addr = addr;
        #1;
        chk(tag, {4'h0, rd_data}, {4'h0, exp});
    endtask

    task automatic do_load(input logic [1:0] addr, input logic [3:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Issue one instruction (optionally with a same-cycle load) and follow it
    // through ISSUE, DONE and back to IDLE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic ld, input logic [1:0] la, input logic [3:0] ld_d,
                          input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] er);
        @(negedge clk);
        chk({tag, ".ready_idle"}, {7'd0, instr_ready}, 8'd1);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        ld_en       = ld;
        ld_addr     = la;
        ld_data     = ld_d;
        @(negedge clk);
        instr_valid = 1'b0;
        ld_en       = 1'b0;
        chk({tag, ".alu_a"},    {4'h0, alu_a}, {4'h0, ea});
        chk({tag, ".alu_b"},    {4'h0, alu_b}, {4'h0, eb});
        chk({tag, ".alu_ctrl"}, {5'd0, alu_ctrl}, {5'd0, op});
        chk({tag, ".ready_issue"}, {7'd0, instr_ready}, 8'd0);
        chk({tag, ".done_issue"},  {7'd0, done}, 8'd0);
        @(negedge clk);
        chk({tag, ".done"},   {7'd0, done}, 8'd1);
        chk({tag, ".res_q"},  {4'h0, res_q}, {4'h0, er});
        chk({tag, ".zero_q"}, {7'd0, zero_q}, {7'd0, (er == 4'h0)});
        @(negedge clk);
        chk({tag, ".done_clr"}, {7'd0, done}, 8'd0);
        chk_rf({tag, ".rf_rd"}, rd, er);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr_op = 3'd0;
        instr_rd = 2'd0;
        instr_rs1 = 2'd0;
        instr_rs2 = 2'd0;
        ld_en = 1'b0;
        ld_addr = 2'd0;
        ld_data = 4'd0;
        rd_addr = 2'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst.ready",  {7'd0, instr_ready}, 8'd1);
        chk("rst.done",   {7'd0, done}, 8'd0);
        chk("rst.res_q",  {4'h0, res_q}, 8'd0);
        chk("rst.zero_q", {7'd0, zero_q}, 8'd1);
        chk("rst.alu_a",  {4'h0, alu_a}, 8'd0);
        chk_rf("rst.rf0", 2'd0, 4'h0);
        rst = 1'b0;

        // AND: 1100 & 1010 = 1000 into r2.
        do_load(2'd0, 4'b1100);
        do_load(2'd1, 4'b1010);
        run_op("and", 3'b000, 2'd2, 2'd0, 2'd1, 1'b0, 2'd0, 4'd0, 4'b1100, 4'b1010, 4'b1000);

        // SUB 0100 - 0010 = 0010 into r3, then ADD r3+r3 = 0100 into r3.
        do_load(2'd0, 4'b0100);
        do_load(2'd1, 4'b0010);
        run_op("sub", 3'b011, 2'd3, 2'd0, 2'd1, 1'b0, 2'd0, 4'd0, 4'b0100, 4'b0010, 4'b0010);
        run_op("add33", 3'b010, 2'd3, 2'd3, 2'd3, 1'b0, 2'd0, 4'd0, 4'b0010, 4'b0010, 4'b0100);

        // Same-cycle load of r1=0111 with OR r0|r1, r0=0000: bypass gives 0111.
        do_load(2'd0, 4'b0000);
        run_op("byp", 3'b001, 2'd2, 2'd0, 2'd1, 1'b1, 2'd1, 4'b0111, 4'b0000, 4'b0111, 4'b0111);
        chk_rf("byp.rf1", 2'd1, 4'b0111);

        // 1111 + 0001 wraps to 0000 into r0.
        do_load(2'd0, 4'b1111);
        do_load(2'd1, 4'b0001);
        run_op("wrap", 3'b010, 2'd0, 2'd0, 2'd1, 1'b0, 2'd0, 4'd0, 4'b1111, 4'b0001, 4'b0000);

        // Continuous valid: accepts every 3 cycles; ld_en in ISSUE is ignored.
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = 3'b000;
        instr_rd    = 2'd2;
        instr_rs1   = 2'd1;
        instr_rs2   = 2'd1;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("stream.ready%0d", k), {7'd0, instr_ready}, {7'd0, (k % 3 == 0)});
            chk($sformatf("stream.done%0d", k),  {7'd0, done}, {7'd0, (k % 3 == 2)});
            if (k % 3 == 1) begin
                ld_en   = 1'b1;
                ld_addr = 2'd1;
                ld_data = 4'b0101;
            end else begin
                ld_en   = 1'b0;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        ld_en = 1'b0;
        chk_rf("stream.rf1", 2'd1, 4'b0001);
        chk_rf("stream.rf2", 2'd2, 4'b0001);
`ifdef ALU_SEQ_PERF_EN
        chk("perf.count", op_count, 8'd8);
`endif

        // Reset asserted during ISSUE discards the in-flight ADD into r0.
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = 3'b010;
        instr_rd    = 2'd0;
        instr_rs1   = 2'd1;
        instr_rs2   = 2'd1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("rstiss.pre_a", {4'h0, alu_a}, 8'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstiss.ready", {7'd0, instr_ready}, 8'd1);
        chk("rstiss.done",  {7'd0, done}, 8'd0);
        chk("rstiss.alu_a", {4'h0, alu_a}, 8'd0);
        chk("rstiss.alu_b", {4'h0, alu_b}, 8'd0);
        chk("rstiss.ctrl",  {5'd0, alu_ctrl}, 8'd0);
        chk("rstiss.res_q", {4'h0, res_q}, 8'd0);
        chk("rstiss.zero_q", {7'd0, zero_q}, 8'd1);
        for (int r = 0; r < 4; r++) begin
            chk_rf($sformatf("rstiss.rf%0d", r), r[1:0], 4'h0);
        end
`ifdef ALU_SEQ_PERF_EN
        chk("rstiss.count", op_count, 8'd0);
`endif
        @(negedge clk);
        chk("rstiss.done_after", {7'd0, done}, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstiss.done_post", {7'd0, done}, 8'd0);
        chk_rf("rstiss.rf0_post", 2'd0, 4'h0);
        chk("rstiss.res_post", {4'h0, res_q}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
